// File: rtl/fnd_scan_display.sv
// fnd_scan_display
// Captures a 14-bit binary value, converts it to four BCD digits with a
// sequential shift-add-3 engine (one bit per clock), and multiplexes the
// result onto a common-anode 4-digit seven-segment display.
module fnd_scan_display #(
    parameter int SCAN_DIV = 100000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_en,
    output logic [3:0]  o_FND_Digit,
    output logic [7:0]  o_FND_Font,
    output logic        o_busy,
    output logic        o_ovf
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    // conversion engine state
    logic [0:0]  state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_pend_q, ovf_pend_d;

    // committed display contents
    logic [15:0] shadow_q, shadow_d;
    logic        ovf_q, ovf_d;

    // scan timing and registered outputs
    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic [3:0]    digit_q, digit_d;
    logic [7:0]    font_q, font_d;

    logic [15:0] bcd_adj;
    logic [15:0] bcd_shift;
    logic [3:0]  blank;
    logic [3:0]  cur_nib;

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign bcd_shift = {bcd_adj[14:0], bin_q[13]};

    // A digit is blanked when it and every higher digit are zero; the units
    // digit always shows.
    assign blank[0] = 1'b0;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_blank
            assign blank[gi] = LZ_BLANK && (shadow_q[15:gi*4] == '0);
        end
    endgenerate

    assign cur_nib = shadow_q[{idx_q, 2'b00} +: 4];

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // Next-state logic for the capture / conversion FSM.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        shadow_d   = shadow_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (i_load) begin
                    bin_d      = i_value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = 1'b0;
                    state_d    = S_CONV;
                end
            end
            default: begin
                bin_d = {bin_q[12:0], 1'b0};
                bcd_d = bcd_shift;
                cnt_d = cnt_q + 4'd1;
                // A one leaving the thousands nibble means the value has a
                // ten-thousands digit, i.e. it exceeds 9999.
                ovf_pend_d = ovf_pend_q | bcd_adj[15];
                if (cnt_q == 4'd13) begin
                    state_d = S_IDLE;
                    ovf_d   = ovf_pend_q | bcd_adj[15];
                    if (!(ovf_pend_q | bcd_adj[15])) begin
                        shadow_d = bcd_shift;
                    end
                end
            end
        endcase
    end

    // Conversion engine and committed digit registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            shadow_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            shadow_q   <= shadow_d;
            ovf_q      <= ovf_d;
        end
    end

    // Free-running prescaler stepping the digit index on every wrap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Select anode and segment pattern for the current slot.
    always_comb begin
        digit_d = 4'b1111;
        font_d  = 8'hFF;
        if (i_en) begin
            digit_d = ~(4'b0001 << idx_q);
            if (ovf_q) begin
                font_d = 8'hBF;
            end else if (blank[idx_q]) begin
                font_d = 8'hFF;
            end else begin
                font_d = seg_code(cur_nib);
            end
        end
    end

    // Register the display drive so anode and segments change together.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            digit_q <= 4'b1111;
            font_q  <= 8'hFF;
        end else begin
            digit_q <= digit_d;
            font_q  <= font_d;
        end
    end

    assign o_FND_Digit = digit_q;
    assign o_FND_Font  = font_q;
    assign o_busy      = (state_q == S_CONV);
    assign o_ovf       = ovf_q;

endmodule
